// File: rtl/philv_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: default widths, PC step and fetch FSM encoding.
package philv_fetch_unit_pkg;

  localparam int unsigned Xlen       = 32;
  localparam int unsigned InstrWidth = 32;
  localparam int unsigned PcIncr     = 4;

  typedef enum logic [0:0] {
    FsIdle = 1'b0,
    FsReq  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/philv_fetch_unit_fifo.sv
// Synchronous fetch buffer holding {pc, instr} entries with push/pop/flush and occupancy count.
module philv_fetch_unit_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam logic [Aw:0] DepthCnt = (Aw+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] last_q;
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      count_q;
  logic             push_ok, pop_ok;

  assign valid_o = (count_q != '0);
  assign pop_ok  = pop_i & valid_o;
  // A push into a full buffer is only legal when the same-cycle pop frees a slot.
  assign push_ok = push_i & ((count_q != DepthCnt) | pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (valid_o) begin
        last_q <= mem_q[rd_ptr_q];
      end
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) begin
          mem_q[wr_ptr_q] <= data_i;
          wr_ptr_q        <= wr_ptr_q + Aw'(1);
        end
        if (pop_ok) begin
          rd_ptr_q <= rd_ptr_q + Aw'(1);
        end
        count_q <= count_q + (Aw+1)'(push_ok) - (Aw+1)'(pop_ok);
      end
    end
  end

  // Output the last delivered head while empty so decode never sees stale or X data.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/philv_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-at-a-time imem reads and buffers returned words.
module philv_fetch_unit
  import philv_fetch_unit_pkg::*;
#(
  parameter int unsigned       N           = Xlen,
  parameter int unsigned       INSTR_WIDTH = InstrWidth,
  parameter logic [N-1:0]      RESET_PC    = '0,
  parameter int unsigned       FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  output logic                   imem_req,
  output logic [N-1:0]           imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [N-1:0]           instr_pc,
  input  logic                   redirect_valid,
  input  logic [N-1:0]           redirect_pc,
  output logic [N-1:0]           fetch_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [N-1:0]    fetch_pc_q, fetch_pc_d;
  logic [N-1:0]    req_addr_q, req_addr_d;
  logic            discard_q, discard_d;
  logic            push, pop;
  logic [CntW-1:0] count, base;
  logic [N-1:0]    pc_inc, target;

  assign pop    = instr_valid & instr_ready & ~redirect_valid;
  assign pc_inc = fetch_pc_q + N'(PcIncr);
  assign target = redirect_pc & ~N'(3);
  // Occupancy after this edge, before any push; a redirect empties the buffer.
  assign base   = redirect_valid ? '0 : count - CntW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    unique case (state_q)
      FsIdle: begin
        if (redirect_valid) begin
          fetch_pc_d = target;
          req_addr_d = target;
          state_d    = FsReq;
        end else if (base < DepthCnt) begin
          req_addr_d = fetch_pc_q;
          state_d    = FsReq;
        end
      end
      FsReq: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            fetch_pc_d = target;
            req_addr_d = target;
            discard_d  = 1'b0;
          end else if (discard_q) begin
            discard_d  = 1'b0;
            req_addr_d = fetch_pc_q;
          end else begin
            push       = 1'b1;
            fetch_pc_d = pc_inc;
            req_addr_d = pc_inc;
            state_d    = ((base + CntW'(1)) < DepthCnt) ? FsReq : FsIdle;
          end
        end else if (redirect_valid) begin
          // The in-flight request cannot be aborted; its word is dropped on arrival.
          fetch_pc_d = target;
          discard_d  = 1'b1;
        end
      end
      default: state_d = FsIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= FsIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  assign imem_req  = (state_q == FsReq);
  assign imem_addr = req_addr_q;
  assign fetch_pc  = fetch_pc_q;

  philv_fetch_unit_fifo #(
    .Width (N + INSTR_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rstb),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({req_addr_q, imem_rdata}),
    .pop_i   (pop),
    .valid_o (instr_valid),
    .data_o  ({instr_pc, instr}),
    .count_o (count)
  );

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Directed bench for philv_fetch_unit: streaming, backpressure, slow memory, redirects, PC wrap.
module tb_philv_fetch_unit;

  logic        clk = 1'b0;
  logic        rstb;
  logic        imem_ack;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, fetch_pc;

  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_instr_pc, w_fetch_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: returned word is the request address with the low bits of an addi opcode.
  assign imem_rdata   = imem_addr | 32'h13;
  assign w_imem_rdata = w_imem_addr | 32'h13;

  philv_fetch_unit u_dut (
    .clk            (clk),
    .rstb           (rstb),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc)
  );

  philv_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk            (clk),
    .rstb           (rstb),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (w_imem_rdata),
    .instr_valid    (w_instr_valid),
    .instr_ready    (instr_ready),
    .instr          (w_instr),
    .instr_pc       (w_instr_pc),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .fetch_pc       (w_fetch_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick(2);
    rstb = 1'b0;
  endtask

  initial begin
    imem_ack    = 1'b1;
    instr_ready = 1'b1;

    // 1: reset values, then zero-wait streaming
    do_reset();
    rstb = 1'b1;
    tick(1);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    rstb = 1'b0;
    tick(1);
    check("s1_req_e1", imem_req, 1);
    check("s1_valid_e1", instr_valid, 0);
    tick(1);
    check("s1_valid_e2", instr_valid, 1);
    check("s1_pc0", instr_pc, 32'h0);
    check("s1_instr0", instr, 32'h13);
    tick(1);
    check("s1_pc4", instr_pc, 32'h4);
    check("s1_instr4", instr, 32'h17);
    tick(1);
    check("s1_pc8", instr_pc, 32'h8);
    tick(1);
    check("s1_pc12", instr_pc, 32'hC);
    check("s1_valid_e5", instr_valid, 1);

    // 2: backpressure fills the buffer and stalls fetch
    instr_ready = 1'b0;
    do_reset();
    tick(10);
    check("s2_req_stall", imem_req, 0);
    check("s2_fetch_pc", fetch_pc, 32'h8);
    check("s2_valid", instr_valid, 1);
    check("s2_head0", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick(1);
    check("s2_head4", instr_pc, 32'h4);
    check("s2_req_resume", imem_req, 1);
    check("s2_addr8", imem_addr, 32'h8);
    tick(1);
    check("s2_head8", instr_pc, 32'h8);
    check("s2_instr8", instr, 32'h1B);

    // 3: three-cycle memory wait
    imem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("s3_wait_req", imem_req, 1);
      check("s3_wait_addr", imem_addr, 32'h0);
      check("s3_wait_valid", instr_valid, 0);
    end
    imem_ack = 1'b1;
    tick(1);
    imem_ack = 1'b0;
    check("s3_valid_after_ack", instr_valid, 1);
    check("s3_pc0", instr_pc, 32'h0);
    tick(1);
    check("s3_drained", instr_valid, 0);
    check("s3_hold_pc", instr_pc, 32'h0);
    check("s3_hold_instr", instr, 32'h13);

    // 4: redirect while the request to 0x8 is outstanding
    imem_ack = 1'b1;
    do_reset();
    tick(3);
    check("s4_pending_addr", imem_addr, 32'h8);
    check("s4_head4", instr_pc, 32'h4);
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick(1);
    redirect_valid = 1'b0;
    check("s4_flushed", instr_valid, 0);
    check("s4_addr_held", imem_addr, 32'h8);
    check("s4_req_held", imem_req, 1);
    check("s4_fetch_pc", fetch_pc, 32'h100);
    tick(1);
    check("s4_addr_held2", imem_addr, 32'h8);
    imem_ack = 1'b1;
    tick(1);
    check("s4_dropped", instr_valid, 0);
    check("s4_new_addr", imem_addr, 32'h100);
    tick(1);
    check("s4_valid_tgt", instr_valid, 1);
    check("s4_pc_tgt", instr_pc, 32'h100);
    check("s4_instr_tgt", instr, 32'h113);

    // 5: redirect coinciding with both an ack and a pop
    do_reset();
    tick(2);
    check("s5_head0", instr_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    check("s5_no_push", instr_valid, 0);
    check("s5_addr_tgt", imem_addr, 32'h200);
    check("s5_fetch_pc", fetch_pc, 32'h200);
    tick(1);
    check("s5_pc_tgt", instr_pc, 32'h200);
    check("s5_instr_tgt", instr, 32'h213);

    // 6: PC wrap from the top of the address space, then reset mid-wait
    do_reset();
    tick(1);
    check("s6_addr_top", w_imem_addr, 32'hFFFF_FFFC);
    tick(1);
    check("s6_pc_top", w_instr_pc, 32'hFFFF_FFFC);
    check("s6_addr_wrap", w_imem_addr, 32'h0);
    check("s6_fetch_wrap", w_fetch_pc, 32'h0);
    imem_ack = 1'b0;
    tick(1);
    check("s6_wait_req", w_imem_req, 1);
    rstb = 1'b1;
    tick(1);
    check("s6_rst_req", w_imem_req, 0);
    check("s6_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
    check("s6_rst_fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);
    check("s6_rst_valid", w_instr_valid, 0);
    check("s6_rst_instr", w_instr, 0);
    check("s6_rst_instr_pc", w_instr_pc, 0);
    check("s6_rst_main_addr", imem_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
